// File: rtl/mul_unit_arbiter.sv
// Four-requester round-robin front end for a shared multiplier.
// One operation in flight; the result is returned to its owner, or a timeout pulse is raised.
module mul_unit_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [3:0]           iReq,
    input  logic [4*WIDTH-1:0]   iA,
    input  logic [4*WIDTH-1:0]   iB,
    input  logic [3:0]           iUnscaled,
    output logic [3:0]           oGrant,
    output logic [WIDTH-1:0]     oMulA,
    output logic [WIDTH-1:0]     oMulB,
    output logic                 oMulUnscaled,
    output logic                 oMulInputReady,
    input  logic [WIDTH-1:0]     iMulR,
    input  logic                 iMulOutputReady,
    output logic [WIDTH-1:0]     oResult,
    output logic [1:0]           oResultId,
    output logic                 oResultValid,
    output logic                 oBusy,
    output logic                 oError
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_prio;
    logic [3:0]  r_cnt;
    logic [1:0]  r_id;

    logic [7:0]  w_dbl;
    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_win;
    logic        w_win_valid;

    // Round-robin pick: rotate requests so the highest-priority index sits at bit 0.
    always_comb begin
        w_dbl       = {iReq, iReq} >> r_prio;
        w_rot       = w_dbl[3:0];
        w_win_valid = |iReq;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else begin
            w_off = 2'd3;
        end
        w_win = r_prio + w_off;
    end

    // Control FSM with all outputs registered; pulse outputs default low each cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state        <= ST_IDLE;
            r_prio         <= 2'd0;
            r_cnt          <= 4'd0;
            r_id           <= 2'd0;
            oGrant         <= 4'd0;
            oMulA          <= '0;
            oMulB          <= '0;
            oMulUnscaled   <= 1'b0;
            oMulInputReady <= 1'b0;
            oResult        <= '0;
            oResultId      <= 2'd0;
            oResultValid   <= 1'b0;
            oBusy          <= 1'b0;
            oError         <= 1'b0;
        end else begin
            oGrant         <= 4'd0;
            oMulInputReady <= 1'b0;
            oResultValid   <= 1'b0;
            oError         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        oMulA          <= iA[{w_win, 5'd0} +: WIDTH];
                        oMulB          <= iB[{w_win, 5'd0} +: WIDTH];
                        oMulUnscaled   <= iUnscaled[w_win];
                        oGrant         <= 4'b0001 << w_win;
                        oMulInputReady <= 1'b1;
                        r_id           <= w_win;
                        r_cnt          <= 4'd0;
                        oBusy          <= 1'b1;
                        r_state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Completion is checked first so it beats a same-cycle timeout.
                    if (iMulOutputReady) begin
                        oResult      <= iMulR;
                        oResultId    <= r_id;
                        oResultValid <= 1'b1;
                        r_prio       <= r_id + 2'd1;
                        r_cnt        <= 4'd0;
                        oBusy        <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (r_cnt == 4'(TIMEOUT - 1)) begin
                        oError       <= 1'b1;
                        r_prio       <= r_id + 2'd1;
                        r_cnt        <= 4'd0;
                        oBusy        <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt        <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    oBusy   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_unit_arbiter.md
MUL_UNIT_ARBITER -- requirements
Module: mul_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; fixed at 32.
REQ-002 Parameter: TIMEOUT, 8, max cycles in WAIT before abort; legal range 3..15.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 iReq  input  4  per-requester request; held high with operands stable until oGrant[i] seen.
REQ-006 iA  input  128  requester i operand A at bits [32i+31:32i], two's complement.
REQ-007 iB  input  128  requester i operand B at bits [32i+31:32i], two's complement.
REQ-008 iUnscaled  input  4  per-requester unscaled-product select.
REQ-009 oGrant  output  4  one-hot, one-cycle acceptance pulse.
REQ-010 oMulA, oMulB  output  32 each  registered operands to multiplier.
REQ-011 oMulUnscaled  output  1  registered unscaled select to multiplier.
REQ-012 oMulInputReady  output  1  one-cycle issue strobe to multiplier.
REQ-013 iMulR  input  32  multiplier result.
REQ-014 iMulOutputReady  input  1  multiplier completion strobe.
REQ-015 oResult  output  32  registered product; oResultId  output  2  owning requester; oResultValid  output  1  one-cycle pulse.
REQ-016 oBusy  output  1  high while in WAIT; oError  output  1  one-cycle timeout pulse.

Function
REQ-017 FSM: two states, IDLE and WAIT; reset state IDLE.
REQ-018 IDLE, iReq==0: no state change; all pulse outputs low.
REQ-019 IDLE, iReq!=0: winner = first asserted index scanning rPrio, rPrio+1, ... mod 4.
REQ-020 On that edge: oMulA/oMulB/oMulUnscaled load winner's iA/iB/iUnscaled, oGrant[winner]=1, oMulInputReady=1, rId=winner, counter=0, state->WAIT.
REQ-021 oMulA, oMulB, oMulUnscaled hold values until next grant (multiplier result depends on held scale select).
REQ-022 WAIT: iReq ignored; oGrant and oMulInputReady low; counter increments each cycle.
REQ-023 WAIT, iMulOutputReady=1: oResult<=iMulR, oResultId<=rId, oResultValid=1 one cycle, rPrio<=rId+1 mod 4, state->IDLE.
REQ-024 WAIT, counter==TIMEOUT-1 and iMulOutputReady=0: oError=1 one cycle, no oResultValid, rPrio<=rId+1 mod 4, state->IDLE.
REQ-025 Completion and timeout on same cycle: completion wins; oError stays low.
REQ-026 iMulOutputReady in IDLE: ignored; no output change.
REQ-027 Nominal latency with 2-cycle multiplier: request sampled at edge E0; grant high E0-E1; result valid after E3; earliest next grant at E4 (one operation per 4 cycles).
REQ-028 oResult, oMulA, oMulB hold last value between operations; oResultValid qualifies oResult.
REQ-029 At most one operation in flight.

Reset
REQ-030 Reset low: immediately, independent of Clock: state IDLE, rPrio=0, counter=0, rId=0, all outputs 0.
REQ-031 Reset asserted during WAIT: in-flight operation discarded; no oResultValid or oError after release.
REQ-032 First evaluation of iReq is at the first rising edge after Reset deasserts.

Verification
REQ-033 iReq=0010, A1=3, B1=5, iUnscaled[1]=1, 2-cycle multiplier model -> oGrant=0010 one cycle; oMulInputReady one cycle; oResult=15, oResultId=1, oResultValid after E3.
REQ-034 iReq=1111 held, each requester re-requests after grant -> grant order 0,1,2,3,0; one grant every 4 cycles.
REQ-035 rPrio=1, iReq=0101 -> grant to 2; then rPrio=3; next iReq=0101 -> grant to 0.
REQ-036 Multiplier stub never asserts ready, TIMEOUT=8 -> oError pulse 8 cycles after entering WAIT; oResultValid stays 0; oBusy falls same edge.
REQ-037 Reset low mid-WAIT, then stub asserts iMulOutputReady -> all outputs 0 at once; no oResultValid; next grant from index 0.
REQ-038 A0=0xFFFFFFFE, B0=3, unscaled -> oResult=0xFFFFFFFA; stray iMulOutputReady while IDLE -> no output change.
